// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types and constants for the serial shifter
package shifter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } shifter_state_t;

endpackage

// File: rtl/serial_shifter32_shift_step.sv
// rtl/serial_shifter32_shift_step.sv - one combinational shift step of 0..BITS_PER_CYCLE bits
module shift_step
    import shifter_pkg::*;
(
    input  logic [WORD_W-1:0] acc_i,
    input  logic              dir_i,
    input  logic              fill_i,
    input  logic [4:0]        step_i,
    output logic [WORD_W-1:0] result_o
);

    logic signed [WORD_W:0] ext;

    // Prepending the fill bit lets one arithmetic shift cover both SRL and SRA.
    always_comb begin
        ext = {fill_i, acc_i};
        if (dir_i) begin
            result_o = WORD_W'(ext >>> step_i);
        end else begin
            result_o = acc_i << step_i;
        end
    end

endmodule

// File: rtl/serial_shifter32.sv
// rtl/serial_shifter32.sv - iterative SLL/SRL/SRA unit with start/busy/done handshake
module serial_shifter32
    import shifter_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [4:0]        amount,
    input  logic [WORD_W-1:0] in,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] out
);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] STEP_MAX = 5'(BITS_PER_CYCLE);

    shifter_state_t    state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d, acc_shifted;
    logic [4:0]        rem_q, rem_d, step;
    logic              fill_q, fill_d;
    logic              dir_q, dir_d;
    logic              accept;

    // Clamp to the remaining distance so the last step may be partial.
    assign step = (rem_q < STEP_MAX) ? rem_q : STEP_MAX;

    shift_step u_step (
        .acc_i    (acc_q),
        .dir_i    (dir_q),
        .fill_i   (fill_q),
        .step_i   (step),
        .result_o (acc_shifted)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        dir_d   = dir_q;
        accept  = start && (state_q != ST_SHIFT);

        case (state_q)
            ST_SHIFT: begin
                acc_d = acc_shifted;
                rem_d = rem_q - step;
                if (rem_q == step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        // A start in DONE overrides the return to IDLE, giving bubble-free chaining.
        if (accept) begin
            acc_d   = in;
            rem_d   = amount;
            dir_d   = op[0];
            fill_d  = (op == 2'(SH_SRA)) && in[WORD_W-1];
            state_d = (amount != 5'd0) ? ST_SHIFT : ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            dir_q   <= dir_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign out  = acc_q;

endmodule

// File: doc/serial_shifter32.md
Name: serial_shifter32

Overview:
- Multi-cycle, area-lean shift unit for the RV32 execution stage.
- Performs SLL/SRL/SRA iteratively, BITS_PER_CYCLE bits per clock, under a start/busy/done handshake.
- Serves as the low-area sequential alternative to the single-cycle combinational shifter in the ALU path.
- Result is held in an internal accumulator and presented on out.

Parameters:
- BITS_PER_CYCLE, 1, shift distance applied per SHIFT cycle; legal values 1, 2, 4, 8; any other value is a compile-time error.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00=SLL, 01=SRL, 11=SRA, 10=reserved (executes as SLL).
- amount  input  5  shift distance 0..31.
- in  input  32  operand.
- busy  output  1  high while an operation is in the SHIFT state.
- done  output  1  one-cycle pulse; out is valid in that cycle.
- out  output  32  result; held until the next accepted start.

Behaviour:
- Reset: one clock; reset and start share that edge.
  - Values after the reset edge: state=IDLE, busy=0, done=0, out=0, remaining=0.
  - Reset wins over start on the same edge.
  - Reset mid-operation aborts the shift. No done pulse is produced for the aborted operation.
- Registers: acc[31:0] (drives out), remaining[4:0], fill bit, direction bit, state.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT; done=1 only in DONE.
- Accept: start=1 at an edge while the state is IDLE or DONE.
  - Loads acc<=in, remaining<=amount, dir<=left for op 00/10, dir<=right for op 01/11.
  - fill<=in[31] for SRA, otherwise fill<=0.
  - Next state: SHIFT if amount!=0, otherwise DONE.
- SHIFT, each edge:
  - step = min(remaining, BITS_PER_CYCLE).
  - Left: acc shifts left by step, filling with 0.
  - Right: acc shifts right by step, filling with the fill bit.
  - remaining <= remaining - step.
  - When the new remaining value is 0, next state is DONE; otherwise stay in SHIFT.
- DONE: lasts one cycle.
  - Next state is IDLE, unless a new start is accepted on that edge, in which case the new operation loads.
  - Back-to-back operations are therefore allowed with no bubble.
- Ignored start: start while busy=1 is ignored, with no queuing and no error.
  - op, amount and in are don't-care outside the accept edge.
- Latency: n = ceil(amount / BITS_PER_CYCLE).
  - done is high in the cycle that begins n+1 edges after the accept edge.
  - amount=0 gives done 1 cycle after accept, with out=in.
- Hold: out holds its value through IDLE. It changes only at the accept edge (load) and during SHIFT.
- Width rules:
  - step never exceeds remaining, so no overshoot occurs.
  - The final step may be partial when BITS_PER_CYCLE does not divide amount.
  - Results are bit-identical to RV32 SLL/SRL/SRA with shamt = amount.

Decomposition:
- Package shifter_pkg holds:
  - shift_op_t enum {SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b11}.
  - shifter_state_t enum {ST_IDLE, ST_SHIFT, ST_DONE}.
  - Localparam WORD_W=32.
- One combinational sub-module, shift_step.
  - Inputs: acc, dir, fill, step.
  - Output: acc shifted by step (0..BITS_PER_CYCLE).
  - The FSM, counter and handshake logic stay in the top module.

Test Plan:
- SLL, in=0x0000_0001, amount=31, BITS_PER_CYCLE=1 -> busy high for 31 cycles; done 32 cycles after accept; out=0x8000_0000.
- SRA, in=0x8000_0000, amount=4 -> out=0xF800_0000, done at cycle 5.
- SRL with the same stimulus -> out=0x0800_0000.
- amount=0, in=0xDEAD_BEEF, op=SRA -> done 1 cycle after accept; out=0xDEAD_BEEF; busy never asserted.
- BITS_PER_CYCLE=4, SRL, in=0xFFFF_FFFF, amount=7:
  - Two SHIFT cycles (4 then 3), done at cycle 3, out=0x01FF_FFFF.
  - A second start with amount=1, op=SLL, in=0x1, asserted in the DONE cycle, is accepted; out=0x0000_0002 two cycles later.
- Robustness: start with in=0x1234_5678 pulsed while busy=1 is ignored (the original result is delivered). reset asserted on the 3rd SHIFT cycle of an amount=10 operation -> next cycle busy=0, done=0, out=0, and no done pulse follows.
